// File: rtl/cdb_arbiter_if.sv
// Requester-side result bus and CDB broadcast bundle for cdb_arbiter.
// The slave modport is the arbiter; the master modport is the FU/register-file side.
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 4
);
    localparam int SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     cdb_rdy;
    logic [TAG_W-1:0]         cdb_tag;
    logic [WIDTH-1:0]         cdb_data;
    logic [SRC_W-1:0]         cdb_src;

    modport master (
        output req_valid, req_tag, req_data,
        input  req_ready, cdb_rdy, cdb_tag, cdb_data, cdb_src
    );

    modport slave (
        input  req_valid, req_tag, req_data,
        output req_ready, cdb_rdy, cdb_tag, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one functional-unit result per cycle onto the broadcast bus.
// Latency: grant in cycle N, result on the CDB in cycle N+1 (cdb_rdy high one cycle).
// Backpressure: req_ready is a one-hot same-cycle grant; losers and flush cycles simply hold.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    cdb_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             cdb_rdy_q, cdb_rdy_d;
    logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
    logic [WIDTH-1:0] cdb_data_q, cdb_data_d;
    logic [IDX_W-1:0] cdb_src_q, cdb_src_d;

    logic [TAG_W-1:0] tag_arr  [NUM_REQ];
    logic [WIDTH-1:0] data_arr [NUM_REQ];

    logic [NUM_REQ-1:0] grant_vec;
    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W:0]     scan_sum;
    logic [IDX_W-1:0]   scan_idx;
    logic               xfer;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign tag_arr[g]  = bus.req_tag[g*TAG_W +: TAG_W];
        assign data_arr[g] = bus.req_data[g*WIDTH +: WIDTH];
    end

    // Scan from rr_ptr upward with wrap; first valid requester wins.
    always_comb begin
        grant_vec   = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (scan_sum >= (IDX_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (IDX_W+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[IDX_W-1:0];
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found         = 1'b1;
                grant_idx           = scan_idx;
                grant_vec[scan_idx] = 1'b1;
            end
        end
    end

    assign xfer          = grant_found & ~flush_i;
    assign bus.req_ready = grant_vec & {NUM_REQ{rst_ni & ~flush_i}};

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        cdb_rdy_d  = 1'b0;
        cdb_tag_d  = cdb_tag_q;
        cdb_data_d = cdb_data_q;
        cdb_src_d  = cdb_src_q;
        if (xfer) begin
            rr_ptr_d   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            cdb_rdy_d  = 1'b1;
            cdb_tag_d  = tag_arr[grant_idx];
            cdb_data_d = data_arr[grant_idx];
            cdb_src_d  = grant_idx;
        end
    end

    // Reset discards any in-flight broadcast; the ROB replays it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            cdb_rdy_q  <= 1'b0;
            cdb_tag_q  <= '0;
            cdb_data_q <= '0;
            cdb_src_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            cdb_rdy_q  <= cdb_rdy_d;
            cdb_tag_q  <= cdb_tag_d;
            cdb_data_q <= cdb_data_d;
            cdb_src_q  <= cdb_src_d;
        end
    end

    assign bus.cdb_rdy  = cdb_rdy_q;
    assign bus.cdb_tag  = cdb_tag_q;
    assign bus.cdb_data = cdb_data_q;
    assign bus.cdb_src  = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed plus randomized bench for cdb_arbiter against a queue-free priority-scan reference.
module tb_cdb_arbiter;
    localparam int N = 4;
    localparam int W = 32;
    localparam int T = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   errors = 0;
    int   checks = 0;

    int          m_ptr;
    logic        m_rdy;
    logic [T-1:0] m_tag;
    logic [W-1:0] m_data;
    int          m_src;
    int          last_g;

    cdb_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .TAG_W(T)) bus();

    cdb_arbiter #(.NUM_REQ(N), .WIDTH(W), .TAG_W(T)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [T-1:0] t, input logic [W-1:0] d);
        bus.req_valid[i]       = v;
        bus.req_tag[i*T +: T]  = t;
        bus.req_data[i*W +: W] = d;
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_rdy  = 1'b0;
        m_tag  = '0;
        m_data = '0;
        m_src  = 0;
        last_g = -1;
    endtask

    // Highest-priority valid requester, counting upward from m_ptr modulo N.
    function automatic int exp_grant();
        for (int k = 0; k < N; k++) begin
            if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // Entered in the low clock phase with inputs already driven; leaves at the next negedge.
    task automatic tick(input string nm);
        int g;
        logic [N-1:0] er;
        logic [T-1:0] gt;
        logic [W-1:0] gd;
        #1;
        g  = exp_grant();
        er = '0;
        gt = '0;
        gd = '0;
        if (g >= 0 && !flush && rst_n) begin
            er[g] = 1'b1;
            gt    = bus.req_tag[g*T +: T];
            gd    = bus.req_data[g*W +: W];
        end
        chk({nm, ".req_ready"}, 64'(bus.req_ready), 64'(er));
        @(posedge clk);
        if (er != '0) begin
            m_rdy  = 1'b1;
            m_tag  = gt;
            m_data = gd;
            m_src  = g;
            m_ptr  = (g + 1) % N;
            last_g = g;
        end else begin
            m_rdy  = 1'b0;
            last_g = -1;
        end
        #1;
        chk({nm, ".cdb_rdy"}, 64'(bus.cdb_rdy), 64'(m_rdy));
        if (m_rdy) begin
            chk({nm, ".cdb_tag"}, 64'(bus.cdb_tag), 64'(m_tag));
            chk({nm, ".cdb_data"}, 64'(bus.cdb_data), 64'(m_data));
            chk({nm, ".cdb_src"}, 64'(bus.cdb_src), 64'(m_src));
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.req_valid = '1;
        bus.req_tag   = '0;
        bus.req_data  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset.req_ready", 64'(bus.req_ready), 64'd0);
        chk("reset.cdb_rdy", 64'(bus.cdb_rdy), 64'd0);
        chk("reset.cdb_tag", 64'(bus.cdb_tag), 64'd0);
        chk("reset.cdb_data", 64'(bus.cdb_data), 64'd0);
        chk("reset.cdb_src", 64'(bus.cdb_src), 64'd0);
        chk("reset.rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
        bus.req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester
        set_req(2, 1'b1, 4'h9, 32'hDEADBEEF);
        #1;
        chk("single.grant", 64'(bus.req_ready), 64'(4'b0100));
        tick("single");
        chk("single.tag", 64'(bus.cdb_tag), 64'h9);
        chk("single.data", 64'(bus.cdb_data), 64'hDEADBEEF);
        chk("single.src", 64'(bus.cdb_src), 64'd2);
        chk("single.rr_ptr", 64'(dut.rr_ptr_q), 64'd3);
        set_req(2, 1'b0, '0, '0);

        // Wrap priority from rr_ptr=3, then from rr_ptr=1
        set_req(0, 1'b1, 4'hA, 32'h0000_000A);
        set_req(3, 1'b1, 4'hB, 32'h0000_000B);
        tick("wrap3a");
        chk("wrap3.first", 64'(bus.cdb_src), 64'd3);
        set_req(3, 1'b0, '0, '0);
        tick("wrap3b");
        chk("wrap3.second", 64'(bus.cdb_src), 64'd0);
        set_req(0, 1'b1, 4'hC, 32'h0000_000C);
        set_req(3, 1'b1, 4'hD, 32'h0000_000D);
        #1;
        chk("wrap1.grant", 64'(bus.req_ready), 64'(4'b1000));
        tick("wrap1a");
        set_req(3, 1'b0, '0, '0);
        tick("wrap1b");
        chk("wrap1.second", 64'(bus.cdb_src), 64'd0);
        set_req(0, 1'b0, '0, '0);
        set_req(3, 1'b1, 4'h0, 32'h0);
        tick("tag0");
        chk("tag0.rdy", 64'(bus.cdb_rdy), 64'd1);
        set_req(3, 1'b0, '0, '0);

        // Fairness with all four held valid
        for (int i = 0; i < N; i++) set_req(i, 1'b1, T'(i + 1), W'(32'h100 + i));
        for (int k = 0; k < 8; k++) begin
            tick("fair");
            chk("fair.seq_tag", 64'(bus.cdb_tag), 64'((k % 4) + 1));
        end

        // Flush squashes one cycle, pointer unchanged
        flush = 1'b1;
        #1;
        chk("flush.ready", 64'(bus.req_ready), 64'd0);
        tick("flush");
        chk("flush.cdb_rdy", 64'(bus.cdb_rdy), 64'd0);
        flush = 1'b0;
        tick("postflush");
        chk("postflush.tag", 64'(bus.cdb_tag), 64'd1);
        for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0);

        // Idle and back-to-back on requester 1
        set_req(1, 1'b1, 4'h5, 32'h55);
        tick("b2b1");
        chk("b2b.rdy1", 64'(bus.cdb_rdy), 64'd1);
        chk("b2b.tag1", 64'(bus.cdb_tag), 64'h5);
        set_req(1, 1'b0, '0, '0);
        tick("b2b2");
        chk("b2b.rdy2", 64'(bus.cdb_rdy), 64'd0);
        set_req(1, 1'b1, 4'h6, 32'h66);
        tick("b2b3");
        chk("b2b.rdy3", 64'(bus.cdb_rdy), 64'd1);
        chk("b2b.tag3", 64'(bus.cdb_tag), 64'h6);
        set_req(1, 1'b0, '0, '0);

        // Asynchronous reset while a result is on the CDB
        set_req(2, 1'b1, 4'h7, 32'h7777_7777);
        tick("prereset");
        chk("midreset.pre_rdy", 64'(bus.cdb_rdy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset.cdb_rdy", 64'(bus.cdb_rdy), 64'd0);
        chk("midreset.cdb_tag", 64'(bus.cdb_tag), 64'd0);
        chk("midreset.cdb_data", 64'(bus.cdb_data), 64'd0);
        chk("midreset.rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
        chk("midreset.ready", 64'(bus.req_ready), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick("replay");
        chk("replay.src", 64'(bus.cdb_src), 64'd2);
        set_req(2, 1'b0, '0, '0);

        // Randomized traffic with holding requesters and occasional flush
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 1'b1, T'($urandom), $urandom);
            end
            flush = ($urandom_range(0, 7) == 0);
            tick("rand");
            if (last_g >= 0) begin
                if ($urandom_range(0, 1) == 1) set_req(last_g, 1'b1, T'($urandom), $urandom);
                else set_req(last_g, 1'b0, '0, '0);
            end
        end
        flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
